ddr_rd_checker: RTL and testbench
=================================

DDR_RD_CHECKER -- requirements
Module: ddr_rd_checker

Interface
REQ-001 Parameter BURST_LEN, default 64, words per read command (1..64).
REQ-002 Parameter NUM_BURSTS, default 16, read commands per check pass (1..65535).
REQ-003 Parameter BASE_ADDR, default 30'h0, first byte address, 4-byte aligned.
REQ-004 Parameter PATTERN_SEED, default 32'hA5A5_0000, XOR term of expected data.
REQ-005 Parameter TIMEOUT, default 1024, maximum idle cycles while waiting for read data.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst_n  in  1  reset; synchronous, active-low.
REQ-008 c3_calib_done  in  1  MCB calibration complete.
REQ-009 start  in  1  single-cycle pulse that begins one check pass.
REQ-010 c3_p2_cmd_en / c3_p2_cmd_instr / c3_p2_cmd_bl / c3_p2_cmd_byte_addr  out  1/3/6/30  MCB port 2 command.
REQ-011 c3_p2_cmd_full  in  1  command FIFO full.
REQ-012 c3_p2_rd_en  out  1; c3_p2_rd_data  in  32; c3_p2_rd_empty, c3_p2_rd_overflow, c3_p2_rd_error  in  1  MCB port 2 read FIFO.
REQ-013 busy, done, pass, timeout, fifo_fault  out  1  status.
REQ-014 error_count  out  32  mismatching words in the last pass.
REQ-015 first_err_addr  out  30; first_err_data  out  32  capture of the first mismatch.

Function
REQ-016 FSM states: IDLE, CMD, DRAIN, NEXT, FINISH.
REQ-017 IDLE -> CMD on start && c3_calib_done; clear error_count, done, pass, timeout, fifo_fault and the first-error capture; load addr = BASE_ADDR and burst_cnt = 0.
REQ-018 Ignore start when c3_calib_done = 0 or when busy = 1.
REQ-019 CMD: while c3_p2_cmd_full = 1, hold with cmd_en = 0. Otherwise assert cmd_en for exactly one cycle with instr = 3'b011 (read, auto-precharge), bl = BURST_LEN-1 and byte_addr = addr, then go to DRAIN with word_cnt = 0.
REQ-020 DRAIN: c3_p2_rd_en = !c3_p2_rd_empty (combinational, first-word fall-through). Accept a word on a cycle where rd_en = 1.
REQ-021 Expected data for an accepted word = {2'b00, word_addr} ^ PATTERN_SEED, where word_addr = addr + 4*word_cnt.
REQ-022 On mismatch, increment error_count, saturating at 32'hFFFF_FFFF.
REQ-023 When the BURST_LEN-th word is accepted, go to NEXT.
REQ-024 NEXT: add 4*BURST_LEN to addr (30-bit wrap) and increment burst_cnt. Go to FINISH if burst_cnt reaches NUM_BURSTS, otherwise go to CMD.
REQ-025 Idle counter: in DRAIN, count cycles with rd_empty = 1 and reset the count on each accepted word. When the count reaches TIMEOUT, set timeout = 1 and go to FINISH.
REQ-026 Set fifo_fault sticky when c3_p2_rd_overflow or c3_p2_rd_error is high in any state other than IDLE.
REQ-027 FINISH, one cycle: done = 1 (held until the next start); pass = (error_count == 0) && !timeout && !fifo_fault; then go to IDLE.
REQ-028 busy = 1 in every state except IDLE.
REQ-029 A start pulse that coincides with FINISH is ignored.
REQ-030 Keep rd_en = 0 outside DRAIN.
REQ-031 Latency: first cmd_en is 1 cycle after an accepted start when cmd_full = 0.

Reset
REQ-032 When rst_n = 0 at a clock edge, reset all outputs and counters to 0 and the FSM to IDLE.
REQ-033 Reset mid-pass abandons the pass without any further cmd_en. The block does not flush residual MCB FIFO data.

Configuration
REQ-034 With DDR_RD_CHECKER_FIRST_ERR_EN defined: on the first mismatch of a pass, latch word_addr into first_err_addr and the received data into first_err_data; later mismatches do not change them.
REQ-035 Without DDR_RD_CHECKER_FIRST_ERR_EN: first_err_addr and first_err_data are constant 0 and no capture registers exist.

Structure
REQ-036 Shared package ddr_pkg holds:
- MCB instruction codes: WRITE = 0, READ = 1, WRITE_AP = 2, READ_AP = 3, REFRESH = 4;
- the FSM state encoding;
- MAX_BURST = 64.
REQ-037 Sub-module ddr_pattern_ref, combinational: word address and seed in, expected word out. The same sub-module is reused by the write-side generator.

Verification
REQ-038 Memory model holds the correct pattern; defaults; start -> 16 cmd_en pulses at addresses 0x000, 0x100, ..., 0xF00; done = 1, pass = 1, error_count = 0.
REQ-039 Word at byte 0x104 corrupted to 32'h0 -> error_count = 1, pass = 0, first_err_addr = 0x104, first_err_data = 0 (macro defined).
REQ-040 cmd_full held high for 10 cycles at the second command -> no cmd_en during the hold; all commands complete; pass = 1.
REQ-041 Model returns only 63 of 64 words in burst 3 -> timeout = 1 exactly TIMEOUT idle cycles after the last word; done = 1, pass = 0.
REQ-042 rd_overflow pulsed once mid-pass -> fifo_fault = 1, pass = 0. Start while busy and start with calib_done = 0 -> no effect.
REQ-043 rst_n = 0 during burst 5 -> next cycle busy = 0, cmd_en = 0, rd_en = 0 and error_count = 0. A fresh start then runs a clean pass.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR read checker and its companion write-side generator:
// MCB command codes, checker FSM encoding and the maximum burst length.
package ddr_pkg;

  localparam logic [2:0] MCB_WRITE    = 3'd0;
  localparam logic [2:0] MCB_READ     = 3'd1;
  localparam logic [2:0] MCB_WRITE_AP = 3'd2;
  localparam logic [2:0] MCB_READ_AP  = 3'd3;
  localparam logic [2:0] MCB_REFRESH  = 3'd4;

  localparam int MAX_BURST = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/ddr_pattern_ref.sv
// Expected memory word for a given word address; shared by the read checker and
// the write-side pattern generator so both sides agree on the data pattern.
module ddr_pattern_ref (
  input  logic [29:0] i_word_addr,
  input  logic [31:0] i_seed,
  output logic [31:0] o_expected
);

  assign o_expected = {2'b00, i_word_addr} ^ i_seed;

endmodule

// File: rtl/ddr_rd_checker.sv
// Reads NUM_BURSTS bursts from MCB port 2 and compares each word with the address
// pattern. First-mismatch capture is built only when DDR_RD_CHECKER_FIRST_ERR_EN is defined.
//
// state     | meaning
// ST_IDLE   | waiting for start with calibration complete
// ST_CMD    | issuing one read command, held off while the command FIFO is full
// ST_DRAIN  | accepting and checking BURST_LEN words, watching for an idle timeout
// ST_NEXT   | advancing address and burst counter
// ST_FINISH | one cycle: publish done and pass
module ddr_rd_checker
  import ddr_pkg::*;
#(
  parameter int          BURST_LEN    = 64,
  parameter int          NUM_BURSTS   = 16,
  parameter logic [29:0] BASE_ADDR    = 30'h0,
  parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0000,
  parameter int          TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c3_calib_done,
  input  logic        start,
  output logic        c3_p2_cmd_en,
  output logic [2:0]  c3_p2_cmd_instr,
  output logic [5:0]  c3_p2_cmd_bl,
  output logic [29:0] c3_p2_cmd_byte_addr,
  input  logic        c3_p2_cmd_full,
  output logic        c3_p2_rd_en,
  input  logic [31:0] c3_p2_rd_data,
  input  logic        c3_p2_rd_empty,
  input  logic        c3_p2_rd_overflow,
  input  logic        c3_p2_rd_error,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic        fifo_fault,
  output logic [31:0] error_count,
  output logic [29:0] first_err_addr,
  output logic [31:0] first_err_data
);

  localparam int          IDLE_W      = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [6:0]  WC_LAST     = 7'(BURST_LEN - 1);
  localparam logic [5:0]  BL_CODE     = 6'(BURST_LEN - 1);
  localparam logic [29:0] BURST_BYTES = 30'(4 * BURST_LEN);
  localparam logic [15:0] BURST_LAST  = 16'(NUM_BURSTS);

  state_t            r_state;
  logic [29:0]       r_addr;
  logic [15:0]       r_burst_cnt;
  logic [6:0]        r_word_cnt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_done;
  logic              r_pass;
  logic              r_timeout;
  logic              r_fifo_fault;
  logic [31:0]       r_error_count;

  logic              w_start_ok;
  logic              w_cmd_en;
  logic              w_rd_en;
  logic [29:0]       w_word_addr;
  logic [31:0]       w_expected;
  logic              w_mismatch;

  assign w_start_ok  = (r_state == ST_IDLE) && start && c3_calib_done;
  // Command and read handshakes must see this cycle's full/empty flags, so they stay combinational.
  assign w_cmd_en    = (r_state == ST_CMD) && !c3_p2_cmd_full;
  assign w_rd_en     = (r_state == ST_DRAIN) && !c3_p2_rd_empty;
  assign w_word_addr = r_addr + {21'd0, r_word_cnt, 2'b00};
  assign w_mismatch  = w_rd_en && (c3_p2_rd_data != w_expected);

  ddr_pattern_ref u_pattern_ref (
    .i_word_addr (w_word_addr),
    .i_seed      (PATTERN_SEED),
    .o_expected  (w_expected)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_burst_cnt   <= '0;
      r_word_cnt    <= '0;
      r_idle_cnt    <= '0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
      r_fifo_fault  <= 1'b0;
      r_error_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state       <= ST_CMD;
            r_addr        <= BASE_ADDR;
            r_burst_cnt   <= '0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_fifo_fault  <= 1'b0;
            r_error_count <= '0;
          end
        end
        ST_CMD: begin
          if (w_cmd_en) begin
            r_state    <= ST_DRAIN;
            r_word_cnt <= '0;
            r_idle_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (w_rd_en) begin
            r_idle_cnt <= '0;
            r_word_cnt <= r_word_cnt + 7'd1;
            if (w_mismatch && (r_error_count != 32'hFFFF_FFFF))
              r_error_count <= r_error_count + 32'd1;
            if (r_word_cnt == WC_LAST)
              r_state <= ST_NEXT;
          end else if (r_idle_cnt == IDLE_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_FINISH;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        ST_NEXT: begin
          r_addr      <= r_addr + BURST_BYTES;
          r_burst_cnt <= r_burst_cnt + 16'd1;
          r_state     <= ((r_burst_cnt + 16'd1) == BURST_LAST) ? ST_FINISH : ST_CMD;
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_pass  <= (r_error_count == 32'd0) && !r_timeout && !r_fifo_fault;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if ((r_state != ST_IDLE) && (c3_p2_rd_overflow || c3_p2_rd_error))
        r_fifo_fault <= 1'b1;
    end
  end

`ifdef DDR_RD_CHECKER_FIRST_ERR_EN
  logic [29:0] r_first_err_addr;
  logic [31:0] r_first_err_data;

  // error_count still zero marks the first mismatch of the pass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_first_err_addr <= '0;
      r_first_err_data <= '0;
    end else if (w_start_ok) begin
      r_first_err_addr <= '0;
      r_first_err_data <= '0;
    end else if (w_mismatch && (r_error_count == 32'd0)) begin
      r_first_err_addr <= w_word_addr;
      r_first_err_data <= c3_p2_rd_data;
    end
  end

  assign first_err_addr = r_first_err_addr;
  assign first_err_data = r_first_err_data;
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

  assign c3_p2_cmd_en        = w_cmd_en;
  assign c3_p2_cmd_instr     = (r_state == ST_CMD) ? MCB_READ_AP : 3'd0;
  assign c3_p2_cmd_bl        = (r_state == ST_CMD) ? BL_CODE : 6'd0;
  assign c3_p2_cmd_byte_addr = r_addr;
  assign c3_p2_rd_en         = w_rd_en;

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout     = r_timeout;
  assign fifo_fault  = r_fifo_fault;
  assign error_count = r_error_count;

endmodule

// File: tb/tb_ddr_rd_checker.sv
// Directed bench for ddr_rd_checker with a small MCB port-2 read model.
module tb_ddr_rd_checker;

  localparam logic [31:0] SEED = 32'hA5A5_0000;
  localparam int          TMO  = 1024;
  localparam logic [29:0] NONE = 30'h3FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c3_calib_done;
  logic        start;
  logic        c3_p2_cmd_en;
  logic [2:0]  c3_p2_cmd_instr;
  logic [5:0]  c3_p2_cmd_bl;
  logic [29:0] c3_p2_cmd_byte_addr;
  logic        c3_p2_cmd_full;
  logic        c3_p2_rd_en;
  logic [31:0] c3_p2_rd_data;
  logic        c3_p2_rd_empty;
  logic        c3_p2_rd_overflow;
  logic        c3_p2_rd_error;
  logic        busy, done, pass, timeout, fifo_fault;
  logic [31:0] error_count;
  logic [29:0] first_err_addr;
  logic [31:0] first_err_data;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_pop = 0;
  int          last_pop_cyc = 0;
  logic [31:0] rd_q[$];
  logic [29:0] cmd_q[$];
  logic [29:0] bad_addr = NONE;
  logic [29:0] short_addr = NONE;
  logic        flush = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddr_rd_checker dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .c3_calib_done       (c3_calib_done),
    .start               (start),
    .c3_p2_cmd_en        (c3_p2_cmd_en),
    .c3_p2_cmd_instr     (c3_p2_cmd_instr),
    .c3_p2_cmd_bl        (c3_p2_cmd_bl),
    .c3_p2_cmd_byte_addr (c3_p2_cmd_byte_addr),
    .c3_p2_cmd_full      (c3_p2_cmd_full),
    .c3_p2_rd_en         (c3_p2_rd_en),
    .c3_p2_rd_data       (c3_p2_rd_data),
    .c3_p2_rd_empty      (c3_p2_rd_empty),
    .c3_p2_rd_overflow   (c3_p2_rd_overflow),
    .c3_p2_rd_error      (c3_p2_rd_error),
    .busy                (busy),
    .done                (done),
    .pass                (pass),
    .timeout             (timeout),
    .fifo_fault          (fifo_fault),
    .error_count         (error_count),
    .first_err_addr      (first_err_addr),
    .first_err_data      (first_err_data)
  );

  // MCB model: handshakes sampled mid-cycle, FIFO state updated 1 unit after the edge.
  initial begin : mcb_model
    logic        pop, push;
    logic [29:0] ca, wa;
    int          nw;
    c3_p2_rd_empty = 1'b1;
    c3_p2_rd_data  = 32'h0;
    forever begin
      @(negedge clk);
      pop  = c3_p2_rd_en;
      push = c3_p2_cmd_en && !c3_p2_cmd_full;
      ca   = c3_p2_cmd_byte_addr;
      @(posedge clk);
      #1;
      if (pop && rd_q.size() > 0) begin
        rd_q.delete(0);
        n_pop++;
        last_pop_cyc = cyc;
      end
      if (push) begin
        cmd_q.push_back(ca);
        nw = (ca == short_addr) ? 63 : 64;
        for (int i = 0; i < nw; i++) begin
          wa = ca + 30'(4 * i);
          rd_q.push_back((wa == bad_addr) ? 32'h0 : ({2'b00, wa} ^ SEED));
        end
      end
      if (flush) begin
        rd_q.delete();
        flush = 1'b0;
      end
      c3_p2_rd_empty = (rd_q.size() == 0);
      c3_p2_rd_data  = (rd_q.size() > 0) ? rd_q[0] : 32'h0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_pass();
    cmd_q.delete();
    n_pop = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int to_cyc);
    int n;
    n = 0;
    to_cyc = -1;
    while (busy && n < 5000) begin
      tick();
      n++;
      if (timeout && to_cyc < 0) to_cyc = cyc;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_cmds(input string tag, input int k);
    int n;
    n = 0;
    while (cmd_q.size() < k && n < 5000) begin
      tick();
      n++;
    end
    check({tag, "_reach"}, (cmd_q.size() >= k) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int tc, n, hits, cmds_before;
    rst_n = 1'b0;
    c3_calib_done = 1'b1;
    start = 1'b0;
    c3_p2_cmd_full = 1'b0;
    c3_p2_rd_overflow = 1'b0;
    c3_p2_rd_error = 1'b0;
    repeat (3) tick();

    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_status", {29'd0, timeout, fifo_fault, c3_p2_cmd_en}, 32'd0);
    check("rst_errcnt", error_count, 32'd0);
    rst_n = 1'b1;
    tick();

    // Clean pass with first-command latency and address sequence
    start_pass();
    check("lat_cmd_en", {31'd0, c3_p2_cmd_en}, 32'd1);
    check("lat_instr", {29'd0, c3_p2_cmd_instr}, 32'd3);
    check("lat_bl", {26'd0, c3_p2_cmd_bl}, 32'd63);
    wait_idle("clean", tc);
    check("clean_ncmd", cmd_q.size(), 32'd16);
    for (int i = 0; i < 16 && i < cmd_q.size(); i++)
      check($sformatf("clean_addr%0d", i), {2'b00, cmd_q[i]}, 32'(i * 32'h100));
    check("clean_done", {31'd0, done}, 32'd1);
    check("clean_pass", {31'd0, pass}, 32'd1);
    check("clean_errcnt", error_count, 32'd0);
    check("clean_words", n_pop, 32'd1024);

    // One corrupted word at byte 0x104
    bad_addr = 30'h104;
    start_pass();
    wait_idle("corrupt", tc);
    bad_addr = NONE;
    check("corrupt_errcnt", error_count, 32'd1);
    check("corrupt_pass", {31'd0, pass}, 32'd0);
`ifdef DDR_RD_CHECKER_FIRST_ERR_EN
    check("corrupt_fea", {2'b00, first_err_addr}, 32'h104);
`else
    check("corrupt_fea", {2'b00, first_err_addr}, 32'h0);
`endif
    check("corrupt_fed", first_err_data, 32'h0);

    // Command FIFO full for 10 cycles while the second command is pending
    start_pass();
    tick();
    c3_p2_cmd_full = 1'b1;
    n = 0;
    while (n_pop < 64 && n < 500) begin
      tick();
      n++;
    end
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (c3_p2_cmd_en) hits++;
    end
    check("full_no_cmd_en", hits, 32'd0);
    check("full_held_cmds", cmd_q.size(), 32'd1);
    check("full_busy", {31'd0, busy}, 32'd1);
    c3_p2_cmd_full = 1'b0;
    wait_idle("full", tc);
    check("full_ncmd", cmd_q.size(), 32'd16);
    check("full_pass", {31'd0, pass}, 32'd1);
    check("full_fea_clr", {2'b00, first_err_addr}, 32'h0);

    // Burst 3 delivers only 63 words
    short_addr = 30'h300;
    start_pass();
    wait_idle("tmo", tc);
    short_addr = NONE;
    check("tmo_flag", {31'd0, timeout}, 32'd1);
    check("tmo_delay", tc - last_pop_cyc, TMO);
    check("tmo_done", {31'd0, done}, 32'd1);
    check("tmo_pass", {31'd0, pass}, 32'd0);
    check("tmo_ncmd", cmd_q.size(), 32'd4);

    // Overflow pulse mid-pass, plus a start while busy
    start_pass();
    wait_cmds("ovf", 3);
    c3_p2_rd_overflow = 1'b1;
    start = 1'b1;
    tick();
    c3_p2_rd_overflow = 1'b0;
    start = 1'b0;
    wait_idle("ovf", tc);
    check("ovf_fault", {31'd0, fifo_fault}, 32'd1);
    check("ovf_pass", {31'd0, pass}, 32'd0);
    check("ovf_errcnt", error_count, 32'd0);
    check("busy_start_ncmd", cmd_q.size(), 32'd16);
    if (cmd_q.size() == 16) check("busy_start_last", {2'b00, cmd_q[15]}, 32'hF00);

    // Start without calibration
    c3_calib_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("nocal_busy", {31'd0, busy}, 32'd0);
    check("nocal_done", {31'd0, done}, 32'd1);
    check("nocal_fault", {31'd0, fifo_fault}, 32'd1);
    c3_calib_done = 1'b1;

    // Reset during burst 5, with an error already counted in burst 4
    bad_addr = 30'h404;
    start_pass();
    wait_cmds("rst", 6);
    repeat (10) tick();
    check("prerst_errcnt", error_count, 32'd1);
    rst_n = 1'b0;
    flush = 1'b1;
    tick();
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_cmd_en", {31'd0, c3_p2_cmd_en}, 32'd0);
    check("midrst_rd_en", {31'd0, c3_p2_rd_en}, 32'd0);
    check("midrst_errcnt", error_count, 32'd0);
    cmds_before = cmd_q.size();
    tick();
    rst_n = 1'b1;
    bad_addr = NONE;
    repeat (5) tick();
    check("postrst_no_cmd", cmd_q.size(), 32'(cmds_before));

    start_pass();
    wait_idle("fresh", tc);
    check("fresh_ncmd", cmd_q.size(), 32'd16);
    check("fresh_pass", {31'd0, pass}, 32'd1);
    check("fresh_errcnt", error_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
